inspectable_chain_node: RTL and testbench



---
 rtl/inspectable_chain_node.sv | 150 +++++++++++++++
 tb/tb_inspectable_chain_node.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/inspectable_chain_node.sv
// inspectable_chain_node
//   One link of the inspectable-variable daisy chain. Request words addressed
//   to this node's variable (valid bit clear, variable_index match) are
//   answered with a burst of 16-bit flits taken from a snapshot of var_value.
//   All other words pass through unchanged with one cycle of latency.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   upstream handshake, in_data = 64-bit InspectableValue
//   out_valid/out_ready downstream handshake, out_data = 64-bit InspectableValue
//   var_value           live contents of the inspected variable
//
// InspectableValue packing, MSB first:
//   retry, last_element, last_flit, valid, flit_index[11:0],
//   element_index[15:0], variable_index[15:0], value[15:0]
module inspectable_chain_node #(
  parameter int VARIABLE_INDEX = 0,
  parameter int DATA_WIDTH     = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [63:0]           in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [63:0]           out_data,
  input  logic                  out_ready,
  input  logic [DATA_WIDTH-1:0] var_value
);

  localparam int          NUM_FLITS   = (DATA_WIDTH + 15) / 16;
  localparam int          PAD_W       = NUM_FLITS * 16;
  localparam int          IDX_W       = (NUM_FLITS > 1) ? $clog2(NUM_FLITS) : 1;
  localparam logic [11:0] LAST_IDX    = 12'(NUM_FLITS - 1);
  localparam logic [12:0] NUM_FLITS_U = 13'(NUM_FLITS);
  localparam logic [15:0] VAR_IDX     = 16'(VARIABLE_INDEX);

  typedef struct packed {
    logic        retry;
    logic        last_element;
    logic        last_flit;
    logic        valid;
    logic [11:0] flit_index;
    logic [15:0] element_index;
    logic [15:0] variable_index;
    logic [15:0] value;
  } iv_t;

  typedef enum logic {IDLE, BURST} state_t;

  state_t                      state;
  iv_t                         req;
  iv_t                         out_word;
  logic [11:0]                 cnt;
  logic [15:0]                 elem_q;
  logic [PAD_W-1:0]            var_pad;
  logic [NUM_FLITS-1:0][15:0]  live_flits;
  logic [NUM_FLITS-1:0][15:0]  snapshot;
  logic [11:0]                 next_cnt;
  logic                        accept;
  logic                        match;
  logic                        in_range;

  assign req      = iv_t'(in_data);
  assign out_data = out_word;

  // zero-extend so the top flit reads zeros above DATA_WIDTH
  always_comb begin
    var_pad                   = '0;
    var_pad[DATA_WIDTH-1:0]   = var_value;
  end
  assign live_flits = var_pad;

  // rst gates in_ready so nothing is taken while the node is held in reset
  assign in_ready = !rst && (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign match    = !req.valid && (req.variable_index == VAR_IDX);
  assign in_range = {1'b0, req.flit_index} < NUM_FLITS_U;
  assign next_cnt = cnt + 12'd1;

  function automatic iv_t flit_word(input logic [11:0] idx,
                                    input logic [15:0] elem,
                                    input logic [15:0] val);
    iv_t w;
    w.retry          = 1'b0;
    w.last_element   = 1'b1;
    w.last_flit      = (idx == LAST_IDX);
    w.valid          = 1'b1;
    w.flit_index     = idx;
    w.element_index  = elem;
    w.variable_index = VAR_IDX;
    w.value          = val;
    return w;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_word  <= '0;
      cnt       <= '0;
      elem_q    <= '0;
      snapshot  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            out_valid <= 1'b1;
            if (!match) begin
              out_word <= req;
            end else if (!in_range) begin
              // out-of-range flit: single retry response, value forced to 0
              out_word              <= req;
              out_word.retry        <= 1'b1;
              out_word.last_element <= 1'b1;
              out_word.last_flit    <= 1'b1;
              out_word.valid        <= 1'b1;
              out_word.value        <= '0;
            end else begin
              // first flit comes from the live value, which equals the snapshot
              snapshot <= live_flits;
              cnt      <= req.flit_index;
              elem_q   <= req.element_index;
              out_word <= flit_word(req.flit_index, req.element_index,
                                    live_flits[req.flit_index[IDX_W-1:0]]);
              state    <= BURST;
            end
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
        end
        BURST: begin
          // out_valid is always high here
          if (out_ready) begin
            if (out_word.last_flit) begin
              out_valid <= 1'b0;
              state     <= IDLE;
            end else begin
              cnt      <= next_cnt;
              out_word <= flit_word(next_cnt, elem_q,
                                    snapshot[next_cnt[IDX_W-1:0]]);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inspectable_chain_node.sv
module tb_inspectable_chain_node;

  localparam int VI = 5;
  localparam int DW = 40;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [63:0]   in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [63:0]   out_data;
  logic          out_ready = 1'b1;
  logic [DW-1:0] var_value = 40'h12_3456_789A;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  inspectable_chain_node #(.VARIABLE_INDEX(VI), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .var_value(var_value)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mk(input logic r, input logic le, input logic lf,
                                     input logic v, input logic [11:0] fi,
                                     input logic [15:0] ei, input logic [15:0] vi,
                                     input logic [15:0] val);
    return {r, le, lf, v, fi, ei, vi, val};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // monitor: every downstream handshake pops one expected word
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word actual=%h required=none", out_data);
      end else begin
        chk("out_word", out_data, exp_q.pop_front());
      end
    end
  end

  // called at posedge+1; returns at posedge+1 just after the accept edge
  task automatic send(input logic [63:0] w);
    bit ok = 0;
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
    @(posedge clk) #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) begin ok = 1; break; end
    end
    if (!ok) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge clk) #1;
  endtask

  logic [63:0] w;
  logic [63:0] f1;

  initial begin
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk) #1;

    // forward: other variable
    w = mk(1'b0, 1'b0, 1'b1, 1'b0, 12'h00A, 16'h1234, 16'd7, 16'hBEEF);
    exp_q.push_back(w);
    send(w);
    @(negedge clk);
    chk("fwd_in_ready", 64'(in_ready), 64'd1);
    chk("fwd_out_valid", 64'(out_valid), 64'd1);
    drain();

    // forward: valid bit set on our own variable is not a request
    w = mk(1'b1, 1'b1, 1'b0, 1'b1, 12'h000, 16'h0001, 16'd5, 16'hCAFE);
    exp_q.push_back(w);
    send(w);
    drain();

    // full burst from flit 0
    exp_q.push_back(mk(0, 1, 0, 1, 12'd0, 16'h0033, 16'd5, 16'h789A));
    exp_q.push_back(mk(0, 1, 0, 1, 12'd1, 16'h0033, 16'd5, 16'h3456));
    exp_q.push_back(mk(0, 1, 1, 1, 12'd2, 16'h0033, 16'd5, 16'h0012));
    send(mk(0, 0, 0, 0, 12'd0, 16'h0033, 16'd5, 16'h0000));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("burst_in_ready_low", 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    chk("burst_done_in_ready", 64'(in_ready), 64'd1);
    chk("burst_done_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk) #1;

    // partial burst from flit 1, variable changes after the accept edge
    exp_q.push_back(mk(0, 1, 0, 1, 12'd1, 16'h0007, 16'd5, 16'h3456));
    exp_q.push_back(mk(0, 1, 1, 1, 12'd2, 16'h0007, 16'd5, 16'h0012));
    send(mk(0, 0, 0, 0, 12'd1, 16'h0007, 16'd5, 16'h0000));
    var_value = '0;
    drain();
    var_value = 40'h12_3456_789A;

    // out of range flit 3
    exp_q.push_back(mk(1, 1, 1, 1, 12'd3, 16'h0042, 16'd5, 16'h0000));
    send(mk(0, 0, 0, 0, 12'd3, 16'h0042, 16'd5, 16'hAAAA));
    drain();

    // backpressure: stall on flit 1 for 4 cycles
    f1 = mk(0, 1, 0, 1, 12'd1, 16'h0009, 16'd5, 16'h3456);
    exp_q.push_back(mk(0, 1, 0, 1, 12'd0, 16'h0009, 16'd5, 16'h789A));
    exp_q.push_back(f1);
    exp_q.push_back(mk(0, 1, 1, 1, 12'd2, 16'h0009, 16'd5, 16'h0012));
    send(mk(0, 0, 0, 0, 12'd0, 16'h0009, 16'd5, 16'h0000));
    @(posedge clk) #1;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_out_data", out_data, f1);
    end
    @(posedge clk) #1;
    out_ready = 1'b1;
    drain();

    // toggling out_ready
    exp_q.push_back(mk(0, 1, 0, 1, 12'd0, 16'h000B, 16'd5, 16'h789A));
    exp_q.push_back(mk(0, 1, 0, 1, 12'd1, 16'h000B, 16'd5, 16'h3456));
    exp_q.push_back(mk(0, 1, 1, 1, 12'd2, 16'h000B, 16'd5, 16'h0012));
    send(mk(0, 0, 0, 0, 12'd0, 16'h000B, 16'd5, 16'h0000));
    for (int i = 0; i < 10; i++) begin
      out_ready = ~out_ready;
      @(posedge clk) #1;
    end
    out_ready = 1'b1;
    drain();

    // reset mid-burst: only flit 0 must ever appear
    exp_q.push_back(mk(0, 1, 0, 1, 12'd0, 16'h000C, 16'd5, 16'h789A));
    send(mk(0, 0, 0, 0, 12'd0, 16'h000C, 16'd5, 16'h0000));
    @(posedge clk) #1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_data", out_data, 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk) #1;
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk) #1;
    w = mk(0, 0, 0, 0, 12'h005, 16'h0000, 16'd9, 16'h5A5A);
    exp_q.push_back(w);
    send(w);
    drain();
    repeat (5) @(posedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
